// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcodes, FSM
// states, datapath select codes and error codes.
package mips_pkg;

    // Inst[31:26] opcode values
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    // FSM state encoding is visible on the debug port, so values are fixed
    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRead = 4'd3,
        StMemWb   = 4'd4,
        StMemWrite= 4'd5,
        StExec    = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StImmExec = 4'd10,
        StImmWb   = 4'd11,
        StError   = 4'd15
    } state_t;

    // alu_op codes
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_IMM   = 2'b11;

    // pc_src codes
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // alu_src_b codes
    localparam logic [1:0] SRC_B_RT       = 2'b00;
    localparam logic [1:0] SRC_B_FOUR     = 2'b01;
    localparam logic [1:0] SRC_B_SEXT     = 2'b10;
    localparam logic [1:0] SRC_B_SEXT_SH2 = 2'b11;

    // err_code values
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled memory cycles and flags a timeout once the
// allowed number of wait cycles has been used up and memory is still not ready.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_mem_req,
    input  logic i_mem_ready,
    output logic o_timeout
);

    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

    logic [CW-1:0] r_cnt;
    logic          w_at_limit;

    assign w_at_limit = (r_cnt == LIMIT);
    // A ready in the limit cycle still completes the access
    assign o_timeout  = i_mem_req && !i_mem_ready && w_at_limit;

    // Wait counter: restart on state change or any cycle that is not a stall
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_clear || !i_mem_req || i_mem_ready) begin
            r_cnt <= '0;
        end else if (!w_at_limit) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/
// write-back over a shared ALU and memory port and drives datapath selects.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter bit          ENABLE_IMM  = 1'b1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [5:0]       i_opcode,
    input  logic             i_zero,
    input  logic             i_mem_ready,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic             o_iord,
    output logic             o_ir_write,
    output logic             o_pc_en,
    output logic [1:0]       o_pc_src,
    output logic             o_alu_src_a,
    output logic [1:0]       o_alu_src_b,
    output logic [1:0]       o_alu_op,
    output logic             o_reg_dst,
    output logic             o_mem_to_reg,
    output logic             o_reg_write,
    output logic             o_instr_done,
    output logic             o_err,
    output logic [1:0]       o_err_code,
    output logic [3:0]       o_state,
    output logic [CNT_W-1:0] o_instr_count
);

    state_t             r_state;
    state_t             w_state_d;
    logic               r_err;
    logic [1:0]         r_err_code;
    logic [CNT_W-1:0]   r_instr_count;
    logic               w_timeout;
    logic               w_state_change;

    assign w_state_change = (w_state_d != r_state);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (w_state_change),
        .i_mem_req  (o_mem_req),
        .i_mem_ready(i_mem_ready),
        .o_timeout  (w_timeout)
    );

    // State register plus sticky error capture on entry to ERROR
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StFetch;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_state <= w_state_d;
            if (w_state_d == StError && r_state != StError) begin
                r_err      <= 1'b1;
                r_err_code <= (r_state == StDecode) ? ERR_ILLEGAL : ERR_TIMEOUT;
            end
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_instr_count <= '0;
        end else if (o_instr_done) begin
            r_instr_count <= r_instr_count + CNT_W'(1);
        end
    end

    // Next-state decode
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StFetch: begin
                if (w_timeout)        w_state_d = StError;
                else if (i_mem_ready) w_state_d = StDecode;
            end
            StDecode: begin
                case (i_opcode)
                    OP_LW, OP_SW:              w_state_d = StMemAddr;
                    OP_RTYPE:                  w_state_d = StExec;
                    OP_BEQ:                    w_state_d = StBranch;
                    OP_J:                      w_state_d = StJump;
                    OP_ADDI, OP_ANDI, OP_ORI:  w_state_d = ENABLE_IMM ? StImmExec : StError;
                    default:                   w_state_d = StError;
                endcase
            end
            StMemAddr:  w_state_d = (i_opcode == OP_SW) ? StMemWrite : StMemRead;
            StMemRead: begin
                if (w_timeout)        w_state_d = StError;
                else if (i_mem_ready) w_state_d = StMemWb;
            end
            StMemWrite: begin
                if (w_timeout)        w_state_d = StError;
                else if (i_mem_ready) w_state_d = StFetch;
            end
            StExec:     w_state_d = StAluWb;
            StImmExec:  w_state_d = StImmWb;
            StMemWb, StAluWb, StBranch, StJump, StImmWb: w_state_d = StFetch;
            StError:    w_state_d = StError;
            default:    w_state_d = StError;
        endcase
    end

    // Datapath controls per state; enables are forced low while reset is held
    always_comb begin
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_iord       = 1'b0;
        o_ir_write   = 1'b0;
        o_pc_en      = 1'b0;
        o_pc_src     = PC_SRC_ALU;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = SRC_B_RT;
        o_alu_op     = ALU_OP_ADD;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_reg_write  = 1'b0;
        o_instr_done = 1'b0;
        case (r_state)
            StFetch: begin
                o_mem_req   = 1'b1;
                o_alu_src_b = SRC_B_FOUR;
                o_ir_write  = i_mem_ready;
                o_pc_en     = i_mem_ready;
            end
            StDecode:   o_alu_src_b = SRC_B_SEXT_SH2;
            StMemAddr: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRC_B_SEXT;
            end
            StMemRead: begin
                o_mem_req = 1'b1;
                o_iord    = 1'b1;
            end
            StMemWb: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
                o_instr_done = 1'b1;
            end
            StMemWrite: begin
                o_mem_req    = 1'b1;
                o_mem_we     = 1'b1;
                o_iord       = 1'b1;
                o_instr_done = i_mem_ready;
            end
            StExec: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = ALU_OP_FUNCT;
            end
            StAluWb: begin
                o_reg_write  = 1'b1;
                o_reg_dst    = 1'b1;
                o_instr_done = 1'b1;
            end
            StBranch: begin
                o_alu_src_a  = 1'b1;
                o_alu_op     = ALU_OP_SUB;
                o_pc_src     = PC_SRC_ALUOUT;
                o_pc_en      = i_zero;
                o_instr_done = 1'b1;
            end
            StJump: begin
                o_pc_src     = PC_SRC_JUMP;
                o_pc_en      = 1'b1;
                o_instr_done = 1'b1;
            end
            StImmExec: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRC_B_SEXT;
                o_alu_op    = ALU_OP_IMM;
            end
            StImmWb: begin
                o_reg_write  = 1'b1;
                o_instr_done = 1'b1;
            end
            default: ;
        endcase
        if (i_reset) begin
            o_mem_req    = 1'b0;
            o_mem_we     = 1'b0;
            o_ir_write   = 1'b0;
            o_pc_en      = 1'b0;
            o_reg_write  = 1'b0;
            o_instr_done = 1'b0;
        end
    end

    assign o_state       = r_state;
    assign o_err         = r_err;
    assign o_err_code    = r_err_code;
    assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Main instance: MEM_TIMEOUT=3,
// CNT_W=4; a second instance with ENABLE_IMM=0 shares the inputs.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       mem_req, mem_we, iord, ir_write, pc_en, alu_src_a;
    logic       reg_dst, mem_to_reg, reg_write, instr_done, err;
    logic [1:0] pc_src, alu_src_b, alu_op, err_code;
    logic [3:0] state, instr_count;

    logic       n_mem_req, n_mem_we, n_iord, n_ir_write, n_pc_en, n_alu_src_a;
    logic       n_reg_dst, n_mem_to_reg, n_reg_write, n_instr_done, n_err;
    logic [1:0] n_pc_src, n_alu_src_b, n_alu_op, n_err_code;
    logic [3:0] n_state, n_instr_count;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(3), .ENABLE_IMM(1'b1), .CNT_W(4)) u_dut (
        .i_clk(clk), .i_reset(reset), .i_opcode(opcode), .i_zero(zero),
        .i_mem_ready(mem_ready), .o_mem_req(mem_req), .o_mem_we(mem_we), .o_iord(iord),
        .o_ir_write(ir_write), .o_pc_en(pc_en), .o_pc_src(pc_src),
        .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b), .o_alu_op(alu_op),
        .o_reg_dst(reg_dst), .o_mem_to_reg(mem_to_reg), .o_reg_write(reg_write),
        .o_instr_done(instr_done), .o_err(err), .o_err_code(err_code),
        .o_state(state), .o_instr_count(instr_count)
    );

    multicycle_control #(.MEM_TIMEOUT(15), .ENABLE_IMM(1'b0), .CNT_W(4)) u_noimm (
        .i_clk(clk), .i_reset(reset), .i_opcode(opcode), .i_zero(zero),
        .i_mem_ready(mem_ready), .o_mem_req(n_mem_req), .o_mem_we(n_mem_we),
        .o_iord(n_iord), .o_ir_write(n_ir_write), .o_pc_en(n_pc_en), .o_pc_src(n_pc_src),
        .o_alu_src_a(n_alu_src_a), .o_alu_src_b(n_alu_src_b), .o_alu_op(n_alu_op),
        .o_reg_dst(n_reg_dst), .o_mem_to_reg(n_mem_to_reg), .o_reg_write(n_reg_write),
        .o_instr_done(n_instr_done), .o_err(n_err), .o_err_code(n_err_code),
        .o_state(n_state), .o_instr_count(n_instr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
        next(); next();
        chk("rst_state", state, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_err", {err, err_code}, 0);
        chk("rst_mem_req_gated", mem_req, 0);

        // R-type, ready tied high: 0 -> 1 -> 6 -> 7 -> 0
        reset = 1'b0; #1;
        chk("r_fetch_state", state, 0);
        chk("r_fetch_ctl", {mem_req, iord, ir_write, pc_en, alu_src_b}, 6'b101101);
        chk("r_fetch_wr", reg_write, 0);
        next();
        chk("r_decode", {state, alu_src_a, alu_src_b, alu_op}, {4'd1, 1'b0, 2'b11, 2'b00});
        next();
        chk("r_exec", {state, alu_src_a, alu_src_b, alu_op, reg_write},
            {4'd6, 1'b1, 2'b00, 2'b10, 1'b0});
        next();
        chk("r_aluwb", {state, reg_write, reg_dst, mem_to_reg, instr_done},
            {4'd7, 4'b1101});
        chk("r_aluwb_count", instr_count, 0);
        next(); exp_cnt = 1;
        chk("r_done_state", state, 0);
        chk("r_done_count", instr_count, exp_cnt);

        // lw with two wait states on the data read: 7 cycles
        opcode = 6'b100011; #1;
        chk("lw_fetch_ir", ir_write, 1);
        next(); mem_ready = 1'b0; #1;
        chk("lw_decode", {state, mem_req}, {4'd1, 1'b0});
        next();
        chk("lw_memaddr", {state, alu_src_a, alu_src_b, alu_op}, {4'd2, 1'b1, 2'b10, 2'b00});
        next();
        chk("lw_rd_wait1", {state, mem_req, iord, mem_we}, {4'd3, 3'b110});
        next();
        chk("lw_rd_wait2", {state, mem_req, iord}, {4'd3, 2'b11});
        next(); mem_ready = 1'b1; #1;
        chk("lw_rd_ready", {state, mem_req, iord}, {4'd3, 2'b11});
        next();
        chk("lw_memwb", {state, reg_write, mem_to_reg, reg_dst, instr_done},
            {4'd4, 4'b1101});
        next(); exp_cnt++;
        chk("lw_done", {state, instr_count}, {4'd0, 4'(exp_cnt)});

        // beq taken then not taken
        opcode = 6'b000100; zero = 1'b1;
        next(); next();
        chk("beq1_branch", {state, pc_en, pc_src, instr_done, alu_op},
            {4'd8, 1'b1, 2'b01, 1'b1, 2'b01});
        next(); exp_cnt++;
        zero = 1'b0;
        next(); next();
        chk("beq0_branch", {state, pc_en, instr_done}, {4'd8, 1'b0, 1'b1});
        next(); exp_cnt++;
        chk("beq_count", instr_count, exp_cnt);

        // addi: main decodes it, ENABLE_IMM=0 instance errors in cycle 3
        reset = 1'b1; next(); reset = 1'b0; exp_cnt = 0;
        opcode = 6'b001000;
        next(); next();
        chk("imm_exec", {state, alu_src_a, alu_src_b, alu_op}, {4'd10, 1'b1, 2'b10, 2'b11});
        chk("noimm_err", {n_state, n_err, n_err_code, n_mem_req}, {4'd15, 1'b1, 2'b01, 1'b0});
        next();
        chk("imm_wb", {state, reg_write, reg_dst, mem_to_reg, instr_done}, {4'd11, 4'b1001});
        next(); exp_cnt++;
        chk("imm_done", {state, instr_count}, {4'd0, 4'(exp_cnt)});
        chk("noimm_sticky", n_state, 15);

        // Illegal opcode 111111: ERROR in cycle 3, held until reset
        opcode = 6'b111111;
        next(); next();
        chk("ill_err", {state, err, err_code, mem_req, instr_done}, {4'd15, 1'b1, 2'b01, 2'b00});
        next(); next();
        chk("ill_hold", {state, err, ir_write, pc_en}, {4'd15, 1'b1, 2'b00});
        reset = 1'b1; next(); reset = 1'b0; #1; exp_cnt = 0;
        chk("ill_reset", {state, err, err_code, instr_count}, {4'd0, 3'b000, 4'd0});
        chk("noimm_reset", {n_state, n_err}, {4'd0, 1'b0});
        chk("ill_reset_req", mem_req, 1);

        // Fetch timeout: three stall cycles are allowed, a fourth without ready errors
        mem_ready = 1'b0; opcode = 6'b000000;
        next(); next(); next();
        chk("to_last_wait", {state, mem_req, ir_write, pc_en}, {4'd0, 3'b100});
        next();
        chk("to_err", {state, err, err_code}, {4'd15, 1'b1, 2'b10});
        reset = 1'b1; next(); reset = 1'b0;
        next(); next(); next();
        mem_ready = 1'b1; #1;
        chk("to_ready_wins", {state, ir_write}, {4'd0, 1'b1});
        next();
        chk("to_no_err", {state, err}, {4'd1, 1'b0});
        next(); next(); next();
        chk("to_r_done", {state, instr_count}, {4'd0, 4'd1});

        // sw, zero wait: FETCH -> DECODE -> MEMADDR -> MEMWRITE -> FETCH
        reset = 1'b1; next(); reset = 1'b0; exp_cnt = 0;
        opcode = 6'b101011;
        next(); next(); next();
        chk("sw_write", {state, mem_req, mem_we, iord, instr_done}, {4'd5, 4'b1111});
        next(); exp_cnt++;
        chk("sw_done", {state, instr_count}, {4'd0, 4'(exp_cnt)});

        // sw again, reset while stalled in MEMWRITE
        next(); next(); mem_ready = 1'b0;
        next(); #1;
        chk("swr_wait", {state, mem_we, instr_done}, {4'd5, 1'b1, 1'b0});
        next();
        reset = 1'b1; mem_ready = 1'b1; #1;
        chk("swr_rst_gate", {mem_req, mem_we, instr_done}, 3'b000);
        chk("swr_rst_count", instr_count, exp_cnt);
        next(); reset = 1'b0; #1; exp_cnt = 0;
        chk("swr_after", {state, instr_count}, {4'd0, 4'd0});

        // 16 jumps wrap a 4-bit count back to 0
        opcode = 6'b000010;
        for (int i = 0; i < 16; i++) begin
            next(); next();
            if (i == 0) begin
                chk("j_jump", {state, pc_en, pc_src, instr_done}, {4'd9, 1'b1, 2'b10, 1'b1});
            end
            next(); exp_cnt = (exp_cnt + 1) % 16;
            chk($sformatf("j_count_%0d", i), instr_count, exp_cnt);
        end
        chk("j_wrap_zero", instr_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, required finish before 100000");
        $fatal(1, "bench time limit");
    end

endmodule
